// File: rtl/display_pkg.sv
// Shared glyph constants, bus payload types and helpers for the 7-segment scan driver.
// Glyphs are active-high with bit6 = a ... bit0 = g.
package display_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [3:0] CODE_MINUS = 4'd10;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic neg;
        logic blank_lz;
        logic hex_mode;
    } disp_mode_t;

    // One-hot active-high anode vector; callers slice down to their digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot_an(input logic [2:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Datapath-side load port and board-side pin bundle for display_scan_mux.
interface display_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      neg;
    logic                      blank_lz;
    logic                      hex_mode;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      frame_done;
    logic                      sign_ovf;

    modport master (
        output load, value, neg, blank_lz, hex_mode,
        input  an, seg, frame_done, sign_ovf
    );

    modport slave (
        input  load, value, neg, blank_lz, hex_mode,
        output an, seg, frame_done, sign_ovf
    );
endinterface

// File: rtl/seg7_glyph.sv
// Maps one digit code plus blank/minus overrides to active-high 7-segment glyph bits.
module seg7_glyph
    import display_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (minus) begin
            seg_c = SEG_MINUS;
        end else if (!blank) begin
            case (code)
                4'd0:       seg_c = SEG_0;
                4'd1:       seg_c = SEG_1;
                4'd2:       seg_c = SEG_2;
                4'd3:       seg_c = SEG_3;
                4'd4:       seg_c = SEG_4;
                4'd5:       seg_c = SEG_5;
                4'd6:       seg_c = SEG_6;
                4'd7:       seg_c = SEG_7;
                4'd8:       seg_c = SEG_8;
                4'd9:       seg_c = SEG_9;
                CODE_MINUS: seg_c = hex_mode ? SEG_A : SEG_MINUS;
                4'd11:      seg_c = hex_mode ? SEG_B : SEG_BLANK;
                4'd12:      seg_c = hex_mode ? SEG_C : SEG_BLANK;
                4'd13:      seg_c = hex_mode ? SEG_D : SEG_BLANK;
                4'd14:      seg_c = hex_mode ? SEG_E : SEG_BLANK;
                4'd15:      seg_c = hex_mode ? SEG_F : SEG_BLANK;
                default:    seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous value updates,
// leading-zero blanking with a floating minus sign, and per-slot ghosting dead time.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned GHOST_CYC      = 2,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    display_scan_mux_if.slave  bus
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned VW = 4 * NUM_DIGITS;

    // XOR masks: an all-inactive pattern doubles as the polarity inverter.
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW_AN}};
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW_SEG}};

    logic [PW-1:0]          prescaler;
    logic [IW-1:0]          index;
    logic [VW-1:0]          pend_value, act_value, nxt_value;
    disp_mode_t             pend_mode, act_mode, nxt_mode, load_mode;
    logic                   tick, boundary, nxt_ovf;
    logic [IW-1:0]          act_msd, nxt_msd;
    logic [3:0]             cur_code;
    logic                   cur_blank, cur_minus, dead;
    logic [6:0]             glyph_c;
    logic [MAX_DIGITS-1:0]  oh_full;
    logic [NUM_DIGITS-1:0]  an_r, an_nxt;
    logic [6:0]             seg_r, seg_nxt;
    logic                   frame_done_r, sign_ovf_r;

    // Highest digit position holding a nonzero code; 0 when the value is all zero.
    function automatic logic [IW-1:0] find_msd(input logic [VW-1:0] v);
        logic [IW-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (v[4*i +: 4] != 4'd0) m = IW'(i);
        end
        return m;
    endfunction

    // Frame timing and the value that becomes active at the next boundary.
    always_comb begin
        tick      = (prescaler == PW'(SCAN_DIV - 1));
        boundary  = tick && (index == IW'(NUM_DIGITS - 1));
        load_mode = {bus.neg, bus.blank_lz, bus.hex_mode};
        nxt_value = bus.load ? bus.value : pend_value;
        nxt_mode  = bus.load ? load_mode : pend_mode;
        nxt_msd   = find_msd(nxt_value);
        nxt_ovf   = nxt_mode.neg &&
                    (!nxt_mode.blank_lz || (nxt_msd == IW'(NUM_DIGITS - 1)));
    end

    // Rendering of the currently scanned digit from the active copy.
    always_comb begin
        act_msd   = find_msd(act_value);
        cur_code  = act_value[4*32'(index) +: 4];
        cur_blank = act_mode.blank_lz && (index > act_msd);
        cur_minus = act_mode.neg && act_mode.blank_lz &&
                    (act_msd != IW'(NUM_DIGITS - 1)) &&
                    (index == act_msd + IW'(1));
        dead      = 32'(prescaler) < GHOST_CYC;
        oh_full   = onehot_an(3'(index));
        an_nxt    = dead ? AN_OFF  : (oh_full[NUM_DIGITS-1:0] ^ AN_OFF);
        seg_nxt   = dead ? SEG_OFF : (glyph_c ^ SEG_OFF);
    end

    seg7_glyph u_glyph (
        .code     (cur_code),
        .hex_mode (act_mode.hex_mode),
        .blank    (cur_blank),
        .minus    (cur_minus),
        .seg_c    (glyph_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            index        <= '0;
            pend_value   <= '0;
            pend_mode    <= '0;
            act_value    <= '0;
            act_mode     <= '0;
            sign_ovf_r   <= 1'b0;
            frame_done_r <= 1'b0;
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
        end else begin
            prescaler    <= tick ? '0 : prescaler + PW'(1);
            frame_done_r <= boundary;
            if (tick) begin
                index <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + IW'(1);
            end
            if (bus.load) begin
                pend_value <= bus.value;
                pend_mode  <= load_mode;
            end
            // A load landing on the boundary bypasses pending so it shows this frame.
            if (boundary) begin
                act_value  <= nxt_value;
                act_mode   <= nxt_mode;
                sign_ovf_r <= nxt_ovf;
            end
            an_r  <= an_nxt;
            seg_r <= seg_nxt;
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.frame_done = frame_done_r;
    assign bus.sign_ovf   = sign_ovf_r;

endmodule
